// File: rtl/av_write_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// av_write_arbiter
//
// Two-requester Avalon-MM write arbiter. A debug requester and an MCU
// requester share one registered Avalon-MM write master. While IDLE, a pending
// request is latched into the master registers on the same edge that the FSM
// moves to BUSY. BUSY holds the master strobe, address and data constant until
// the slave accepts (m_av_waitrequest low) or the wait counter reaches
// TIMEOUT_CYCLES. Only in that final cycle does the owning requester see its
// waitrequest drop, so both requesters observe ordinary Avalon write handshakes.
//
// Parameters
//   TIMEOUT_CYCLES  slave-wait cycles before a transfer is aborted (0 = never)
//   PRIORITY_DBG    1: debug wins every tie, 0: round-robin on ties
//
// Ports
//   sysclk, sysreset              clock, synchronous active-high reset
//   dbg_av_address/writedata      debug requester address/data      (in, 16)
//   dbg_av_write                  debug requester write request     (in)
//   dbg_av_waitrequest            debug requester stall             (out)
//   mcu_av_address/writedata      MCU requester address/data        (in, 16)
//   mcu_av_write                  MCU requester write request       (in)
//   mcu_av_waitrequest            MCU requester stall               (out)
//   m_av_address/writedata        shared master address/data, registered (out, 16)
//   m_av_write                    shared master write strobe, registered (out)
//   m_av_waitrequest              slave stall                       (in)
//   grant                         one-hot owner, bit1 debug, bit0 MCU (out, 2)
//   timeout_err                   sticky abort flags, bit1 debug, bit0 MCU (out, 2)
//   err_clear                     clears both timeout_err flags     (in)
// -----------------------------------------------------------------------------
module av_write_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          PRIORITY_DBG   = 1'b0
) (
    input  logic        sysclk,
    input  logic        sysreset,

    input  logic [15:0] dbg_av_address,
    input  logic [15:0] dbg_av_writedata,
    input  logic        dbg_av_write,
    output logic        dbg_av_waitrequest,

    input  logic [15:0] mcu_av_address,
    input  logic [15:0] mcu_av_writedata,
    input  logic        mcu_av_write,
    output logic        mcu_av_waitrequest,

    output logic [15:0] m_av_address,
    output logic [15:0] m_av_writedata,
    output logic        m_av_write,
    input  logic        m_av_waitrequest,

    output logic [1:0]  grant,
    output logic [1:0]  timeout_err,
    input  logic        err_clear
);

    localparam int          N_REQ        = 2;
    localparam logic [15:0] C_TIMEOUT    = 16'(TIMEOUT_CYCLES);
    localparam logic        C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

    // Owner encoding doubles as the index into the per-requester vectors,
    // which keeps it aligned with the bit order of grant and timeout_err.
    localparam logic OWNER_MCU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State registers and their next values
    // -------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic        w_owner_next;
    logic        r_last_owner;
    logic        w_last_owner_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_next;
    logic [15:0] r_addr;
    logic [15:0] w_addr_next;
    logic [15:0] r_data;
    logic [15:0] w_data_next;
    logic        r_write;
    logic        w_write_next;
    logic [1:0]  r_timeout_err;
    logic [1:0]  w_timeout_err_next;

    // -------------------------------------------------------------------------
    // Requester views gathered into vectors indexed by owner encoding
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] w_req;
    logic [15:0]      w_req_addr [N_REQ];
    logic [15:0]      w_req_data [N_REQ];

    assign w_req[0]      = mcu_av_write;
    assign w_req[1]      = dbg_av_write;
    assign w_req_addr[0] = mcu_av_address;
    assign w_req_addr[1] = dbg_av_address;
    assign w_req_data[0] = mcu_av_writedata;
    assign w_req_data[1] = dbg_av_writedata;

    // -------------------------------------------------------------------------
    // Transfer termination
    // -------------------------------------------------------------------------
    logic w_busy;
    logic w_done;
    logic w_abort;
    logic w_release;

    assign w_busy  = (r_state == ST_BUSY);
    assign w_done  = w_busy && !m_av_waitrequest;
    // The counter equals the number of stalled BUSY cycles already seen, so
    // the abort fires on the first stalled cycle after TIMEOUT_CYCLES of them.
    assign w_abort = C_TIMEOUT_EN && w_busy && m_av_waitrequest
                     && (r_wait_cnt == C_TIMEOUT);
    // Reset wins over a completion in the same cycle: neither requester may
    // see its handshake finish on an edge that also resets the arbiter.
    assign w_release = (w_done || w_abort) && !sysreset;

    // -------------------------------------------------------------------------
    // Per-requester outputs: waitrequest, grant bit, error set bit
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] w_waitreq;
    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_err_set;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic w_is_owner;
            assign w_is_owner    = (r_owner == 1'(gi));
            // Stall is the default; only the owner's terminating cycle drops it.
            assign w_waitreq[gi] = !(w_release && w_is_owner);
            assign w_grant[gi]   = w_busy && w_is_owner;
            assign w_err_set[gi] = w_abort && w_is_owner;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic w_winner;

    always_comb begin
        w_winner = OWNER_MCU;
        if (w_req[OWNER_DBG] && w_req[OWNER_MCU]) begin
            // Round-robin tie break hands the bus to whoever did not go last.
            w_winner = PRIORITY_DBG ? OWNER_DBG : ~r_last_owner;
        end else if (w_req[OWNER_DBG]) begin
            w_winner = OWNER_DBG;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_wait_cnt_next   = r_wait_cnt;
        w_addr_next       = r_addr;
        w_data_next       = r_data;
        w_write_next      = r_write;

        case (r_state)
            ST_IDLE: begin
                w_write_next = 1'b0;
                if (|w_req) begin
                    w_state_next    = ST_BUSY;
                    w_owner_next    = w_winner;
                    w_addr_next     = w_req_addr[w_winner];
                    w_data_next     = w_req_data[w_winner];
                    w_write_next    = 1'b1;
                    w_wait_cnt_next = '0;
                end
            end
            ST_BUSY: begin
                // Address/data stay latched here even if the owner drops its
                // request early; the master transfer always runs to the end.
                if (w_done || w_abort) begin
                    w_state_next      = ST_IDLE;
                    w_write_next      = 1'b0;
                    w_last_owner_next = r_owner;
                end else if (m_av_waitrequest && (r_wait_cnt != C_CNT_MAX)) begin
                    // Saturates so a disabled timeout cannot wrap the count.
                    w_wait_cnt_next = r_wait_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_write_next = 1'b0;
            end
        endcase

        // A flag being set in the same cycle as a clear stays set.
        w_timeout_err_next = (r_timeout_err & ~{2{err_clear}}) | w_err_set;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWNER_MCU;
            r_last_owner  <= OWNER_MCU;
            r_wait_cnt    <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_write       <= 1'b0;
            r_timeout_err <= '0;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_last_owner  <= w_last_owner_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_addr        <= w_addr_next;
            r_data        <= w_data_next;
            r_write       <= w_write_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign m_av_address       = r_addr;
    assign m_av_writedata     = r_data;
    assign m_av_write         = r_write;
    assign grant              = w_grant;
    assign timeout_err        = r_timeout_err;
    assign dbg_av_waitrequest = w_waitreq[OWNER_DBG];
    assign mcu_av_waitrequest = w_waitreq[OWNER_MCU];

    // -------------------------------------------------------------------------
    // Design invariants
    // -------------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge sysclk) $onehot0(grant));

    a_release_only_busy: assert property (@(posedge sysclk)
        (!dbg_av_waitrequest || !mcu_av_waitrequest) |-> (r_state == ST_BUSY));

    a_busy_holds: assert property (@(posedge sysclk)
        (!sysreset && (r_state == ST_BUSY) && !w_release)
        |=> (r_write && $stable(r_addr) && $stable(r_data)));

endmodule

// File: tb/tb_av_write_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_av_write_arbiter
//
// Main instance: round-robin, TIMEOUT_CYCLES = 8. Requester drivers push each
// write into a per-requester queue when they raise it; a negedge monitor keeps
// a transaction-level picture of the arbiter (busy/owner/stall count/last
// owner/error flags) and, at every master transfer, compares the bus against
// the head of the owner's queue, popping it when the transfer terminates.
// A second instance with PRIORITY_DBG = 1 checks fixed-priority arbitration.
// -----------------------------------------------------------------------------
module tb_av_write_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        srst;
    logic [15:0] dbg_addr, dbg_data, mcu_addr, mcu_data;
    logic        dbg_write, mcu_write, dbg_wait, mcu_wait;
    logic [15:0] m_addr, m_data;
    logic        m_write, m_wait;
    logic [1:0]  grant, terr;
    logic        err_clear;

    // priority instance signals
    logic        p_srst;
    logic        p_dbg_write, p_mcu_write, p_dbg_wait, p_mcu_wait;
    logic [15:0] p_m_addr, p_m_data;
    logic        p_m_write;
    logic        p_m_wait;
    logic [1:0]  p_grant, p_terr;
    logic        p_err_clear;
    logic [15:0] p_dbg_addr, p_dbg_data, p_mcu_addr, p_mcu_data;

    av_write_arbiter #(.TIMEOUT_CYCLES(TMO), .PRIORITY_DBG(1'b0)) u_dut (
        .sysclk             (clk),
        .sysreset           (srst),
        .dbg_av_address     (dbg_addr),
        .dbg_av_writedata   (dbg_data),
        .dbg_av_write       (dbg_write),
        .dbg_av_waitrequest (dbg_wait),
        .mcu_av_address     (mcu_addr),
        .mcu_av_writedata   (mcu_data),
        .mcu_av_write       (mcu_write),
        .mcu_av_waitrequest (mcu_wait),
        .m_av_address       (m_addr),
        .m_av_writedata     (m_data),
        .m_av_write         (m_write),
        .m_av_waitrequest   (m_wait),
        .grant              (grant),
        .timeout_err        (terr),
        .err_clear          (err_clear)
    );

    av_write_arbiter #(.TIMEOUT_CYCLES(0), .PRIORITY_DBG(1'b1)) u_dut_p (
        .sysclk             (clk),
        .sysreset           (p_srst),
        .dbg_av_address     (p_dbg_addr),
        .dbg_av_writedata   (p_dbg_data),
        .dbg_av_write       (p_dbg_write),
        .dbg_av_waitrequest (p_dbg_wait),
        .mcu_av_address     (p_mcu_addr),
        .mcu_av_writedata   (p_mcu_data),
        .mcu_av_write       (p_mcu_write),
        .mcu_av_waitrequest (p_mcu_wait),
        .m_av_address       (p_m_addr),
        .m_av_writedata     (p_m_data),
        .m_av_write         (p_m_write),
        .m_av_waitrequest   (p_m_wait),
        .grant              (p_grant),
        .timeout_err        (p_terr),
        .err_clear          (p_err_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard queues, entry = {address, data}
    logic [31:0] q_dbg[$];
    logic [31:0] q_mcu[$];

    // -------------------------------------------------------------------------
    // Slave model: random or forced stall count per transfer, or stuck stall
    // -------------------------------------------------------------------------
    bit slave_stuck = 1'b0;
    int slave_force = -1;

    initial begin : slave
        int  wait_left;
        bit  new_xfer;
        m_wait    = 1'b1;
        wait_left = 0;
        new_xfer  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!m_write) begin
                m_wait   = ($urandom_range(0, 1) == 1);
                new_xfer = 1'b1;
            end else begin
                if (new_xfer) begin
                    new_xfer = 1'b0;
                    if (slave_stuck)           wait_left = 1 << 20;
                    else if (slave_force >= 0) wait_left = slave_force;
                    else                       wait_left = int'($urandom_range(0, 3));
                end
                if (wait_left > 0) begin
                    m_wait = 1'b1;
                    wait_left--;
                end else begin
                    m_wait = 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Requester drivers (called at posedge+1, return at posedge+1)
    // -------------------------------------------------------------------------
    function automatic logic wait_of(input bit id);
        return id ? dbg_wait : mcu_wait;
    endfunction

    task automatic drive(input bit id, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (id) begin
            dbg_write = w; dbg_addr = a; dbg_data = d;
        end else begin
            mcu_write = w; mcu_addr = a; mcu_data = d;
        end
    endtask

    task automatic req_write(input bit id, input logic [15:0] a, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        drive(id, 1'b1, a, d);
        if (id) q_dbg.push_back({a, d});
        else    q_mcu.push_back({a, d});
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!srst && !wait_of(id)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        drive(id, 1'b0, a, d);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL req_timeout: requester %0d got no completion, expected one within 400 cycles", id);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / reference model
    // -------------------------------------------------------------------------
    bit          mb_busy  = 1'b0;
    bit          mb_owner = 1'b0;   // 1 = debug
    bit          mb_last  = 1'b0;   // MCU after reset
    int          mb_cnt   = 0;
    logic [15:0] mb_addr  = '0;
    logic [15:0] mb_data  = '0;
    logic [1:0]  mb_terr  = '0;

    initial begin : monitor
        bit          abort_evt, end_evt;
        logic [1:0]  set_v, exp_grant;
        logic [31:0] ent;
        forever begin
            @(negedge clk);
            abort_evt = mb_busy && m_wait && (mb_cnt == TMO);
            end_evt   = mb_busy && !srst && (!m_wait || abort_evt);
            exp_grant = !mb_busy ? 2'b00 : (mb_owner ? 2'b10 : 2'b01);

            check("m_write",     32'(m_write), 32'(mb_busy));
            check("grant",       32'(grant), 32'(exp_grant));
            check("timeout_err", 32'(terr), 32'(mb_terr));
            check("dbg_wait",    32'(dbg_wait), 32'(!(end_evt && mb_owner)));
            check("mcu_wait",    32'(mcu_wait), 32'(!(end_evt && !mb_owner)));
            if (mb_busy) begin
                check("m_addr", 32'(m_addr), 32'(mb_addr));
                check("m_data", 32'(m_data), 32'(mb_data));
            end

            if (srst) begin
                mb_busy = 1'b0;
                mb_last = 1'b0;
                mb_cnt  = 0;
                mb_terr = 2'b00;
            end else begin
                set_v = 2'b00;
                if (!mb_busy) begin
                    if (dbg_write || mcu_write) begin
                        if (dbg_write && mcu_write) mb_owner = !mb_last;
                        else                        mb_owner = dbg_write;
                        if ((mb_owner ? q_dbg.size() : q_mcu.size()) == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL queue_empty: requester %0d granted with nothing issued", mb_owner);
                        end else begin
                            ent = mb_owner ? q_dbg[0] : q_mcu[0];
                            {mb_addr, mb_data} = ent;
                        end
                        mb_busy = 1'b1;
                        mb_cnt  = 0;
                    end
                end else if (end_evt) begin
                    if (mb_owner && q_dbg.size() > 0)       void'(q_dbg.pop_front());
                    else if (!mb_owner && q_mcu.size() > 0) void'(q_mcu.pop_front());
                    $display("xfer %s addr=0x%04h data=0x%04h %s", mb_owner ? "dbg" : "mcu",
                             mb_addr, mb_data, abort_evt ? "abort" : "done");
                    if (abort_evt) set_v[mb_owner] = 1'b1;
                    mb_last = mb_owner;
                    mb_busy = 1'b0;
                end else begin
                    mb_cnt++;
                end
                mb_terr = (mb_terr & ~{2{err_clear}}) | set_v;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fixed-priority instance: both request continuously for 4 transfers
    // -------------------------------------------------------------------------
    bit p_done = 1'b0;

    initial begin : prio_test
        int served, cycles;
        p_srst = 1'b1; p_err_clear = 1'b0; p_m_wait = 1'b0;
        p_dbg_write = 1'b0; p_mcu_write = 1'b0;
        p_dbg_addr = 16'hD0D0; p_dbg_data = 16'hBEEF;
        p_mcu_addr = 16'h1111; p_mcu_data = 16'h2222;
        repeat (2) @(posedge clk);
        #1;
        p_srst = 1'b0;
        p_dbg_write = 1'b1;
        p_mcu_write = 1'b1;
        served = 0;
        cycles = 0;
        while (served < 4 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            check("p_mcu_wait", 32'(p_mcu_wait), 32'd1);
            if (p_m_write) begin
                check("p_grant", 32'(p_grant), 32'h2);
                check("p_m_addr", 32'(p_m_addr), 32'hD0D0);
                if (!p_dbg_wait) served++;
            end
        end
        check("p_served", 32'(served), 32'd4);
        check("p_terr", 32'(p_terr), 32'd0);
        @(posedge clk);
        #1;
        p_dbg_write = 1'b0;
        p_mcu_write = 1'b0;
        p_done = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Main stimulus
    // -------------------------------------------------------------------------
    task automatic pulse_reset();
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    initial begin : main
        srst = 1'b1; err_clear = 1'b0;
        dbg_write = 1'b0; dbg_addr = '0; dbg_data = '0;
        mcu_write = 1'b0; mcu_addr = '0; mcu_data = '0;

        // reset values
        @(posedge clk);
        @(negedge clk);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_terr", 32'(terr), 32'd0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // single MCU write, zero-wait slave
        slave_force = 0;
        req_write(1'b0, 16'h0001, 16'h0041);

        // tie right after reset: debug first, then MCU
        pulse_reset();
        fork
            req_write(1'b1, 16'h0D01, 16'h1001);
            req_write(1'b0, 16'h0C01, 16'h2001);
        join
        // after a debug-only transfer, a tie goes to the MCU
        req_write(1'b1, 16'h0D02, 16'h1002);
        fork
            req_write(1'b1, 16'h0D03, 16'h1003);
            req_write(1'b0, 16'h0C03, 16'h2003);
        join

        // debug transfer stalled 5 cycles, MCU arrives while it is in flight
        slave_force = 5;
        fork
            req_write(1'b1, 16'h0D04, 16'h1004);
            begin
                @(posedge clk);
                #1;
                req_write(1'b0, 16'h0C04, 16'h2004);
            end
        join

        // requester drops request mid-transfer: latched values must complete
        slave_force = 3;
        drive(1'b1, 1'b1, 16'h0D05, 16'h1005);
        q_dbg.push_back({16'h0D05, 16'h1005});
        repeat (2) begin @(posedge clk); #1; end
        drive(1'b1, 1'b0, 16'h5555, 16'hAAAA);
        repeat (8) begin @(posedge clk); #1; end

        // timeout on a stuck slave, then clear
        slave_stuck = 1'b1;
        req_write(1'b1, 16'h0D06, 16'h1006);
        slave_stuck = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;

        // timeout while clear is held: the set must win on that edge
        slave_stuck = 1'b1;
        err_clear   = 1'b1;
        req_write(1'b0, 16'h0C07, 16'h2007);
        slave_stuck = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        err_clear = 1'b0;

        // reset in the second BUSY cycle while the slave is accepting
        slave_force = 1;
        fork
            req_write(1'b0, 16'h0C08, 16'h2008);
            begin
                repeat (2) begin @(posedge clk); #1; end
                srst = 1'b1;
                @(posedge clk);
                #1;
                srst = 1'b0;
                slave_force = -1;
            end
        join

        // randomized traffic from both requesters
        slave_force = -1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    int g;
                    g = int'($urandom_range(0, 3));
                    repeat (g) begin @(posedge clk); #1; end
                    req_write(1'b1, 16'($urandom), 16'($urandom));
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    int g;
                    g = int'($urandom_range(0, 3));
                    repeat (g) begin @(posedge clk); #1; end
                    req_write(1'b0, 16'($urandom), 16'($urandom));
                end
            end
        join

        repeat (5) @(posedge clk);
        for (int i = 0; i < 200 && !p_done; i++) @(posedge clk);
        check("p_done", 32'(p_done), 32'd1);
        check("q_dbg_empty", 32'(q_dbg.size()), 32'd0);
        check("q_mcu_empty", 32'(q_mcu.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/av_write_arbiter.md
AV_WRITE_ARBITER -- requirements
Module: av_write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, master-wait cycles before abort; 0 disables timeout; range 0..65535.
REQ-002 Parameter PRIORITY_DBG, default 0; 1 = debug requester always wins ties, 0 = round-robin.
REQ-003 sysclk  in  1  single clock; all state on rising edge.
REQ-004 sysreset  in  1  synchronous, active-high reset.
REQ-005 dbg_av_address  in  16  debug requester write address.
REQ-006 dbg_av_writedata  in  16  debug requester write data.
REQ-007 dbg_av_write  in  1  debug requester write request.
REQ-008 dbg_av_waitrequest  out  1  debug requester stall.
REQ-009 mcu_av_address, mcu_av_writedata  in  16 each  target MCU requester address/data.
REQ-010 mcu_av_write  in  1  MCU write request; mcu_av_waitrequest  out  1  MCU stall.
REQ-011 m_av_address, m_av_writedata  out  16 each  shared Avalon-MM master address/data, registered.
REQ-012 m_av_write  out  1  shared master write strobe, registered; m_av_waitrequest  in  1  slave stall.
REQ-013 grant  out  2  one-hot current owner, bit1 = debug, bit0 = MCU; 00 when idle.
REQ-014 timeout_err  out  2  sticky abort flags, bit1 = debug, bit0 = MCU; err_clear  in  1  clears both.

Function
REQ-015 Requester protocol SHALL be Avalon-MM write: requester holds write, address, data stable until its waitrequest is low at a rising edge; that edge completes the transfer.
REQ-016 State machine SHALL have states IDLE and BUSY plus a 1-bit owner register and a 1-bit last_owner register.
REQ-017 IDLE: no request pending -> stay IDLE, m_av_write = 0, grant = 00.
REQ-018 IDLE: one or more requests -> latch winner address/data into m_av_address/m_av_writedata, set m_av_write = 1, set owner, go to BUSY on the same edge.
REQ-019 Tie: PRIORITY_DBG = 1 -> debug wins; PRIORITY_DBG = 0 -> the requester that is not last_owner wins.
REQ-020 BUSY: m_av_write, m_av_address, m_av_writedata SHALL hold constant until completion or abort.
REQ-021 Completion: BUSY and m_av_waitrequest = 0 -> transfer done at that edge; owner waitrequest = 0 during that cycle (combinational from m_av_waitrequest); next state IDLE, m_av_write = 0, last_owner = owner.
REQ-022 Requester waitrequest SHALL be 1 in every cycle other than its completion or abort cycle, including while write is deasserted.
REQ-023 Minimum latency: request visible at edge N -> m_av_write high after edge N -> earliest completion at edge N+1; at least one IDLE cycle between consecutive master transfers.
REQ-024 Wait counter (16 bit) SHALL clear on entry to BUSY and increment each BUSY cycle with m_av_waitrequest = 1.
REQ-025 Abort: TIMEOUT_CYCLES != 0 and counter = TIMEOUT_CYCLES with m_av_waitrequest still 1 -> owner waitrequest = 0 that cycle, timeout_err[owner] set, m_av_write = 0 next cycle, state IDLE, last_owner = owner.
REQ-026 timeout_err SHALL clear on err_clear = 1; simultaneous set and clear -> set wins for that bit.
REQ-027 Requester deasserting write while BUSY (protocol violation) SHALL NOT affect the in-flight master transfer; it completes with the latched values.
REQ-028 The non-owning requester SHALL see waitrequest = 1 throughout BUSY and be arbitrated at the next IDLE cycle.

Reset
REQ-029 On sysreset = 1 at an edge: state IDLE, m_av_write = 0, m_av_address = 0, m_av_writedata = 0, grant = 00, timeout_err = 00, counter = 0, last_owner = MCU.
REQ-030 sysreset asserted during BUSY SHALL drop m_av_write after that edge with no completion signalled to either requester; reset dominates all other inputs.

Verification
REQ-031 Single MCU write addr 0x0001 data 0x0041, slave waitrequest 0 -> m_av_write high exactly 1 cycle with 0x0001/0x0041, mcu_av_waitrequest low in that cycle, grant = 01 then 00.
REQ-032 Both request same cycle, PRIORITY_DBG = 0, after reset -> debug served first (last_owner = MCU), MCU served after one IDLE cycle; repeat tie -> MCU first.
REQ-033 Slave holds waitrequest 5 cycles on debug write -> m_av_write/address/data stable 6 cycles, dbg_av_waitrequest low only in final cycle, MCU request waits.
REQ-034 TIMEOUT_CYCLES = 8, slave waitrequest stuck 1 -> abort after 8 wait cycles, timeout_err = owner bit, requester released; err_clear -> timeout_err = 00.
REQ-035 sysreset pulsed in second BUSY cycle -> m_av_write = 0 next cycle, grant = 00, no requester completion, fresh arbitration afterwards.
REQ-036 PRIORITY_DBG = 1, both requesting continuously for 4 transfers -> all 4 granted to debug, MCU waitrequest held 1.
